// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for the word-organised data memory.
// Ports: m_clk/m_rst; lsu_i_* request in; lsu_o_* result out; mem_o_*/mem_i_rdata memory side.
module load_store_unit #(
    parameter int DWIDTH = 32,
    parameter int MEM_AW = 5
) (
    input  logic              m_clk,
    input  logic              m_rst,
    input  logic              lsu_i_valid,
    input  logic              lsu_i_load,
    input  logic              lsu_i_store,
    input  logic [1:0]        lsu_i_size,
    input  logic              lsu_i_unsigned,
    input  logic [31:0]       lsu_i_addr,
    input  logic [DWIDTH-1:0] lsu_i_wdata,
    output logic              lsu_o_stall,
    output logic [DWIDTH-1:0] lsu_o_rdata,
    output logic              lsu_o_done,
    output logic              lsu_o_fault,
    output logic              mem_o_ce,
    output logic              mem_o_rd_en,
    output logic              mem_o_wr_en,
    output logic [MEM_AW-1:0] mem_o_addr,
    output logic [DWIDTH-1:0] mem_o_wdata,
    input  logic [DWIDTH-1:0] mem_i_rdata
);

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [DWIDTH-1:0] merge_q, merge_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic              unused_addr;
    assign unused_addr = ^lsu_i_addr[31:MEM_AW+2];

    logic [MEM_AW-1:0] word_idx;
    assign word_idx = lsu_i_addr[MEM_AW+1:2];

    // Request decode
    logic is_byte, is_half, is_word;
    logic misalign, illegal, req, ok;
    logic ld_ok, st_w_ok, st_sub_ok;

    assign is_byte  = (lsu_i_size == 2'b00);
    assign is_half  = (lsu_i_size == 2'b01);
    assign is_word  = (lsu_i_size == 2'b10);
    assign misalign = (is_half & lsu_i_addr[0])
                    | (is_word & (|lsu_i_addr[1:0]));
    assign illegal  = (lsu_i_size == 2'b11) | misalign
                    | (lsu_i_load & lsu_i_store);
    assign req      = lsu_i_valid & (lsu_i_load | lsu_i_store);
    assign ok       = req & ~illegal & (state_q == IDLE);
    assign ld_ok     = ok & lsu_i_load;
    assign st_w_ok   = ok & lsu_i_store & is_word;
    assign st_sub_ok = ok & lsu_i_store & ~is_word;

    // Load lane extraction: bring the addressed lane down to bit 0
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] ld_ext;
    logic              sx;

    assign shifted = mem_i_rdata >> {lsu_i_addr[1:0], 3'b000};
    assign sx      = ~lsu_i_unsigned;

    always_comb begin
        ld_ext = shifted;
        unique case (1'b1)
            is_byte: ld_ext = {{24{sx & shifted[7]}}, shifted[7:0]};
            is_half: ld_ext = {{16{sx & shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    // Sub-word store merge: replicate store data across lanes,
    // then pick per byte between it and the old memory word.
    logic [DWIDTH-1:0] wrep;
    logic [3:0]        be;
    logic [DWIDTH-1:0] merged;

    assign wrep = is_byte ? {4{lsu_i_wdata[7:0]}}
                          : {2{lsu_i_wdata[15:0]}};

    always_comb begin
        be     = '0;
        merged = mem_i_rdata;
        for (int k = 0; k < 4; k++) begin
            if (is_byte) begin
                be[k] = (lsu_i_addr[1:0] == 2'(k));
            end else begin
                be[k] = (lsu_i_addr[1] == (k >= 2));
            end
            if (be[k]) begin
                merged[8*k +: 8] = wrep[8*k +: 8];
            end
        end
    end

    // FSM next state and outputs
    logic              rd_c, wr_c, stall_c;
    logic [MEM_AW-1:0] addr_c;
    logic [DWIDTH-1:0] wdata_c;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        stall_c = 1'b0;
        addr_c  = word_idx;
        wdata_c = lsu_i_wdata;
        unique case (state_q)
            IDLE: begin
                if (ld_ok) begin
                    rd_c    = 1'b1;
                    rdata_d = ld_ext;
                    done_d  = 1'b1;
                end
                if (st_w_ok) begin
                    wr_c   = 1'b1;
                    done_d = 1'b1;
                end
                if (st_sub_ok) begin
                    rd_c    = 1'b1;
                    stall_c = 1'b1;
                    merge_d = merged;
                    addr_d  = word_idx;
                    state_d = RMW_WRITE;
                end
                if (req & illegal) begin
                    fault_d = 1'b1;
                end
            end
            RMW_WRITE: begin
                wr_c    = 1'b1;
                addr_c  = addr_q;
                wdata_c = merge_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            merge_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Enables are gated by reset so an asserted reset aborts
    // any in-flight access before the next edge.
    assign mem_o_rd_en = rd_c & m_rst;
    assign mem_o_wr_en = wr_c & m_rst;
    assign mem_o_ce    = mem_o_rd_en | mem_o_wr_en;
    assign mem_o_addr  = addr_c;
    assign mem_o_wdata = wdata_c;
    assign lsu_o_stall = stall_c & m_rst;
    assign lsu_o_rdata = rdata_q;
    assign lsu_o_done  = done_q;
    assign lsu_o_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory.
// Ports: drives all DUT inputs, models memory, checks all outputs.
module tb_load_store_unit;

    logic        m_clk;
    logic        m_rst;
    logic        lsu_i_valid;
    logic        lsu_i_load;
    logic        lsu_i_store;
    logic [1:0]  lsu_i_size;
    logic        lsu_i_unsigned;
    logic [31:0] lsu_i_addr;
    logic [31:0] lsu_i_wdata;
    logic        lsu_o_stall;
    logic [31:0] lsu_o_rdata;
    logic        lsu_o_done;
    logic        lsu_o_fault;
    logic        mem_o_ce;
    logic        mem_o_rd_en;
    logic        mem_o_wr_en;
    logic [4:0]  mem_o_addr;
    logic [31:0] mem_o_wdata;
    logic [31:0] mem_i_rdata;

    load_store_unit #(.DWIDTH(32), .MEM_AW(5)) dut (
        .m_clk         (m_clk),
        .m_rst         (m_rst),
        .lsu_i_valid   (lsu_i_valid),
        .lsu_i_load    (lsu_i_load),
        .lsu_i_store   (lsu_i_store),
        .lsu_i_size    (lsu_i_size),
        .lsu_i_unsigned(lsu_i_unsigned),
        .lsu_i_addr    (lsu_i_addr),
        .lsu_i_wdata   (lsu_i_wdata),
        .lsu_o_stall   (lsu_o_stall),
        .lsu_o_rdata   (lsu_o_rdata),
        .lsu_o_done    (lsu_o_done),
        .lsu_o_fault   (lsu_o_fault),
        .mem_o_ce      (mem_o_ce),
        .mem_o_rd_en   (mem_o_rd_en),
        .mem_o_wr_en   (mem_o_wr_en),
        .mem_o_addr    (mem_o_addr),
        .mem_o_wdata   (mem_o_wdata),
        .mem_i_rdata   (mem_i_rdata)
    );

    initial m_clk = 1'b0;
    always #5 m_clk = ~m_clk;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];

    assign mem_i_rdata = mem[mem_o_addr];

    always @(posedge m_clk) begin
        if (mem_o_wr_en) mem[mem_o_addr] <= mem_o_wdata;
    end

    int cyc = 0;
    always @(posedge m_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    typedef struct {
        logic        flt;
        logic [31:0] rd;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [31:0] last_rd = 32'h0;

    always @(negedge m_clk) begin
        if (m_rst && (lsu_o_done || lsu_o_fault)) begin
            if (sb.size() == 0) begin
                chk("spurious", {30'd0, lsu_o_done, lsu_o_fault}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_fault"}, {31'd0, lsu_o_fault}, {31'd0, e.flt});
                chk({e.tag, "_done"}, {31'd0, lsu_o_done}, {31'd0, !e.flt});
                chk({e.tag, "_cyc"}, cyc, e.cyc);
                chk({e.tag, "_rdata"}, lsu_o_rdata, e.rd);
            end
        end
    end

    function automatic logic [31:0] ld_exp(input logic [31:0] wd,
        input logic [1:0] sz, input logic u, input logic [1:0] lo);
        logic [31:0] s;
        s = wd >> (8 * lo);
        case (sz)
            2'd0: return u ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'd1: return u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] st_apply(input logic [31:0] wd,
        input logic [1:0] sz, input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] m;
        m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * lo);
        return (wd & ~m) | ((d << (8 * lo)) & m);
    endfunction

    task automatic drive(input logic v, input logic l, input logic s,
        input logic [1:0] sz, input logic u, input logic [31:0] a,
        input logic [31:0] d);
        lsu_i_valid    = v;
        lsu_i_load     = l;
        lsu_i_store    = s;
        lsu_i_size     = sz;
        lsu_i_unsigned = u;
        lsu_i_addr     = a;
        lsu_i_wdata    = d;
    endtask

    task automatic do_req(input logic l, input logic s,
        input logic [1:0] sz, input logic u, input logic [31:0] a,
        input logic [31:0] d, input string tag);
        logic       bad;
        logic [4:0] w;
        exp_t       x;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0])
           || (sz == 2'd2 && a[1:0] != 2'd0) || (l && s);
        w = a[6:2];
        drive(1'b1, l, s, sz, u, a, d);
        #1;
        x.tag = tag;
        x.flt = bad;
        x.cyc = cyc + 1;
        if (bad) begin
            chk({tag, "_en"}, {29'd0, mem_o_ce, mem_o_rd_en, mem_o_wr_en}, 32'd0);
            x.rd = last_rd;
            sb.push_back(x);
            @(negedge m_clk);
        end else if (l) begin
            chk({tag, "_rden"}, {30'd0, mem_o_rd_en, mem_o_wr_en}, 32'd2);
            chk({tag, "_addr"}, {27'd0, mem_o_addr}, {27'd0, w});
            chk({tag, "_stall"}, {31'd0, lsu_o_stall}, 32'd0);
            last_rd = ld_exp(ref_mem[w], sz, u, a[1:0]);
            x.rd = last_rd;
            sb.push_back(x);
            @(negedge m_clk);
        end else if (sz == 2'd2) begin
            chk({tag, "_wren"}, {30'd0, mem_o_rd_en, mem_o_wr_en}, 32'd1);
            chk({tag, "_wdata"}, mem_o_wdata, d);
            chk({tag, "_stall"}, {31'd0, lsu_o_stall}, 32'd0);
            ref_mem[w] = d;
            x.rd = last_rd;
            sb.push_back(x);
            @(negedge m_clk);
        end else begin
            chk({tag, "_rd_stall"},
                {29'd0, lsu_o_stall, mem_o_rd_en, mem_o_wr_en}, 32'd6);
            ref_mem[w] = st_apply(ref_mem[w], sz, a[1:0], d);
            x.rd = last_rd;
            x.cyc = cyc + 2;
            sb.push_back(x);
            @(negedge m_clk);
            // A request shown in the write cycle must be ignored
            drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
            #1;
            chk({tag, "_wr_stall"},
                {29'd0, lsu_o_stall, mem_o_rd_en, mem_o_wr_en}, 32'd1);
            chk({tag, "_waddr"}, {27'd0, mem_o_addr}, {27'd0, w});
            chk({tag, "_wword"}, mem_o_wdata, ref_mem[w]);
            @(negedge m_clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge m_clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
        mem[1] = 32'hCAFE_F00D;
        mem[3] = 32'h8077_F0A5;
        mem[4] = 32'h1234_5678;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

        m_rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        @(negedge m_clk);
        @(negedge m_clk);
        chk("rst_en", {29'd0, mem_o_ce, mem_o_rd_en, mem_o_wr_en}, 32'd0);
        chk("rst_rdata", lsu_o_rdata, 32'd0);
        chk("rst_pulse", {30'd0, lsu_o_done, lsu_o_fault}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        m_rst = 1'b1;
        @(negedge m_clk);

        do_req(1, 0, 2'd0, 0, 32'h0D, 0, "lb");
        do_req(1, 0, 2'd0, 1, 32'h0D, 0, "lbu");
        do_req(1, 0, 2'd1, 0, 32'h0E, 0, "lh");
        do_req(1, 0, 2'd2, 0, 32'h0C, 0, "lw");
        do_req(0, 1, 2'd0, 0, 32'h0E, 32'h3C, "sb");
        do_req(1, 0, 2'd2, 0, 32'h0C, 0, "lw_sb");
        chk("w3_sb", mem[3], 32'h803C_F0A5);
        do_req(0, 1, 2'd1, 0, 32'h10, 32'hBEEF, "sh");
        do_req(1, 0, 2'd2, 0, 32'h10, 0, "lw_sh");
        do_req(1, 0, 2'd1, 1, 32'h12, 0, "lhu");
        do_req(0, 1, 2'd2, 0, 32'h14, 32'hDEAD_BEEF, "sw");
        do_req(1, 0, 2'd2, 0, 32'h14, 0, "lw_sw");
        do_req(1, 0, 2'd2, 0, 32'h0E, 0, "f_lw");
        do_req(1, 0, 2'd1, 0, 32'h0D, 0, "f_lh");
        do_req(1, 0, 2'd3, 0, 32'h0C, 0, "f_sz");
        do_req(1, 1, 2'd2, 0, 32'h0C, 32'h1111_2222, "f_ls");
        do_req(0, 1, 2'd1, 0, 32'h19, 32'h7777, "f_sh");

        drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        #1;
        chk("nop_en", {29'd0, mem_o_ce, mem_o_rd_en, mem_o_wr_en}, 32'd0);
        @(negedge m_clk);

        for (int i = 0; i < 24; i++) begin
            int op;
            logic [1:0] sz;
            op = $urandom_range(0, 5);
            sz = 2'($urandom_range(0, 3));
            do_req(op < 3, op >= 2, sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 31)), $urandom,
                   $sformatf("rnd%0d", i));
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drain();

        // Reset asserted in the write cycle of a sub-word store
        drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h04, 32'hFF);
        @(negedge m_clk);
        m_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("abort_en", {29'd0, mem_o_ce, mem_o_rd_en, mem_o_wr_en}, 32'd0);
        chk("abort_rdata", lsu_o_rdata, 32'd0);
        chk("abort_pulse", {29'd0, lsu_o_done, lsu_o_fault, lsu_o_stall}, 32'd0);
        @(negedge m_clk);
        m_rst = 1'b1;
        last_rd = 32'h0;
        @(negedge m_clk);
        chk("abort_pulse2", {30'd0, lsu_o_done, lsu_o_fault}, 32'd0);
        do_req(1, 0, 2'd2, 0, 32'h04, 0, "lw_after_rst");
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drain();

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("mem_w%0d", i), mem[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
